dshot_transmitter: RTL and testbench

Serialises one DShot frame onto a single output pin. Each frame carries an 11-bit throttle/command value, a telemetry-request bit and a 4-bit CRC. It is the transmit-side counterpart of the DShot receive path. It is used to drive downstream ESCs and to generate loop-back stimulus for the receiver and speed handler. One frame is accepted per `send`/`ready` handshake; the block then handles the bit timing and the inter-frame gap.

---
 rtl/dshot_pkg.sv | 31 +++
 rtl/dshot_bit_timer.sv | 68 ++++++
 rtl/dshot_transmitter.sv | 140 ++++++++++++++
 tb/tb_dshot_transmitter.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dshot_pkg.sv
// Shared DShot definitions: frame geometry, frame/CRC builders and the
// transmitter state encoding. The receive path reuses dshot_crc for CRCValid.
package dshot_pkg;

  localparam int DSHOT_FRAME_BITS = 16;
  localparam int DSHOT_VALUE_BITS = 11;
  localparam int DSHOT_CMD_MAX    = 47;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BIT  = 2'd1,
    ST_GAP  = 2'd2
  } dshot_state_e;

  // XOR of the three nibbles of the 12-bit payload.
  function automatic logic [3:0] dshot_crc(input logic [11:0] p);
    return p[3:0] ^ p[7:4] ^ p[11:8];
  endfunction

  function automatic logic [15:0] dshot_frame(input logic [DSHOT_VALUE_BITS-1:0] value,
                                              input logic                        telemetry);
    logic [11:0] p;
    p = {value, telemetry};
    return {p, dshot_crc(p)};
  endfunction

  function automatic int dshot_cnt_width(input int bit_cycles, input int gap_cycles);
    return $clog2((bit_cycles > gap_cycles) ? bit_cycles : gap_cycles);
  endfunction

endpackage

// File: rtl/dshot_bit_timer.sv
// Times one DShot bit period: registered line level (high for T0H/T1H cycles)
// and an end-of-bit strobe during the last cycle of the period.
module dshot_bit_timer #(
  parameter int BIT_CYCLES = 80,
  parameter int T0H_CYCLES = 30,
  parameter int T1H_CYCLES = 60,
  parameter int CNT_W      = 7
) (
  input  logic clk,
  input  logic rst,
  input  logic start_i,
  input  logic bit_i,
  output logic level_o,
  output logic bit_end_o
);

  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(BIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] T0H_LEN  = CNT_W'(T0H_CYCLES);
  localparam logic [CNT_W-1:0] T1H_LEN  = CNT_W'(T1H_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             run_q, run_d;
  logic             bit_q, bit_d;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] high_len;

  assign bit_end_o = run_q && (cnt_q == BIT_LAST);
  assign level_o   = level_q;
  assign cnt_inc   = cnt_q + CNT_W'(1);
  assign high_len  = bit_q ? T1H_LEN : T0H_LEN;

  // A restart on the final cycle takes priority, so consecutive bits abut.
  always_comb begin
    cnt_d   = cnt_q;
    run_d   = run_q;
    bit_d   = bit_q;
    level_d = level_q;
    if (start_i) begin
      cnt_d   = '0;
      run_d   = 1'b1;
      bit_d   = bit_i;
      level_d = 1'b1;
    end else if (bit_end_o) begin
      cnt_d   = '0;
      run_d   = 1'b0;
      level_d = 1'b0;
    end else if (run_q) begin
      cnt_d   = cnt_inc;
      level_d = (cnt_inc < high_len);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      run_q   <= 1'b0;
      bit_q   <= 1'b0;
      level_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      run_q   <= run_d;
      bit_q   <= bit_d;
      level_q <= level_d;
    end
  end

endmodule

// File: rtl/dshot_transmitter.sv
// DShot frame serialiser: accepts one {value, telemetry} word per send/ready
// handshake, shifts out 16 bits MSB first, then holds the line low for the gap.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | line low, ready for a frame
//   ST_BIT  | bit timer running, shift register feeds the next bit
//   ST_GAP  | line low for GAP_CYCLES, frame_done on the last gap cycle
module dshot_transmitter
  import dshot_pkg::*;
#(
  parameter int BIT_CYCLES = 80,
  parameter int T0H_CYCLES = 30,
  parameter int T1H_CYCLES = 60,
  parameter int GAP_CYCLES = 160
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DSHOT_VALUE_BITS-1:0] value,
  input  logic                        telemetry,
  input  logic                        send,
  output logic                        ready,
  output logic                        busy,
  output logic                        frame_done,
  output logic                        outPin
);

  localparam int CNT_W = dshot_cnt_width(BIT_CYCLES, GAP_CYCLES);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
  localparam logic [3:0]       IDX_LAST = 4'(DSHOT_FRAME_BITS - 1);

  if (!((T0H_CYCLES >= 1) && (T0H_CYCLES < T1H_CYCLES) &&
        (T1H_CYCLES < BIT_CYCLES) && (GAP_CYCLES >= 1))) begin : g_bad_params
    $error("dshot_transmitter: illegal timing parameter set");
  end

  dshot_state_e     state_q, state_d;
  logic [15:0]      shift_q, shift_d;
  logic [3:0]       bit_idx_q, bit_idx_d;
  logic [CNT_W-1:0] gap_cnt_q, gap_cnt_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic        accept;
  logic [15:0] frame_in;
  logic        timer_start;
  logic        timer_bit;
  logic        bit_end;
  logic        line;

  assign accept   = send && ready_q;
  assign frame_in = dshot_frame(value, telemetry);

  dshot_bit_timer #(
    .BIT_CYCLES(BIT_CYCLES),
    .T0H_CYCLES(T0H_CYCLES),
    .T1H_CYCLES(T1H_CYCLES),
    .CNT_W     (CNT_W)
  ) u_bit_timer (
    .clk      (clk),
    .rst      (rst),
    .start_i  (timer_start),
    .bit_i    (timer_bit),
    .level_o  (line),
    .bit_end_o(bit_end)
  );

  // shift_q holds the bits not yet handed to the timer, next one at [15].
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_idx_d   = bit_idx_q;
    gap_cnt_d   = gap_cnt_q;
    timer_start = 1'b0;
    timer_bit   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d     = ST_BIT;
          shift_d     = {frame_in[14:0], 1'b0};
          bit_idx_d   = '0;
          timer_start = 1'b1;
          timer_bit   = frame_in[15];
        end
      end
      ST_BIT: begin
        if (bit_end) begin
          if (bit_idx_q == IDX_LAST) begin
            state_d   = ST_GAP;
            gap_cnt_d = '0;
          end else begin
            bit_idx_d   = bit_idx_q + 4'd1;
            shift_d     = {shift_q[14:0], 1'b0};
            timer_start = 1'b1;
            timer_bit   = shift_q[15];
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d   = ST_IDLE;
          gap_cnt_d = '0;
        end else begin
          gap_cnt_d = gap_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    ready_d = (state_d == ST_IDLE);
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_GAP) && (gap_cnt_d == GAP_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_idx_q <= '0;
      gap_cnt_q <= '0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      gap_cnt_q <= gap_cnt_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign ready      = ready_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
  assign outPin     = line;

endmodule

// File: tb/tb_dshot_transmitter.sv
// Self-checking bench for dshot_transmitter: default and fast timing instances,
// waveforms compared against a per-cycle model derived from the frame bits.
module tb_dshot_transmitter;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] value;
  logic        telemetry;
  logic        send_a, send_b;
  logic        ready_a, busy_a, done_a, pin_a;
  logic        ready_b, busy_b, done_b, pin_b;

  int n_checks;
  int n_errors;

  logic [3:0] tr[$];  // per cycle: {pin, done, ready, busy}

  always #5 clk = ~clk;

  dshot_transmitter u_dut_a (
    .clk(clk), .rst(rst), .value(value), .telemetry(telemetry), .send(send_a),
    .ready(ready_a), .busy(busy_a), .frame_done(done_a), .outPin(pin_a)
  );

  dshot_transmitter #(
    .BIT_CYCLES(8), .T0H_CYCLES(3), .T1H_CYCLES(6), .GAP_CYCLES(1)
  ) u_dut_b (
    .clk(clk), .rst(rst), .value(value), .telemetry(telemetry), .send(send_b),
    .ready(ready_b), .busy(busy_b), .frame_done(done_b), .outPin(pin_b)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] model_frame(input int v, input int t);
    int p;
    int crc;
    p   = v * 2 + t;
    crc = (p ^ (p >> 4) ^ (p >> 8)) & 15;
    return 16'(p * 16 + crc);
  endfunction

  function automatic void grab(input int sel);
    if (sel == 0) tr.push_back({pin_a, done_a, ready_a, busy_a});
    else          tr.push_back({pin_b, done_b, ready_b, busy_b});
  endfunction

  // Classify each bit by how long the line stayed high within its period.
  function automatic logic [15:0] decode(input int start, input int b, input int t0, input int t1);
    logic [15:0] f;
    int highs;
    f = '0;
    for (int i = 0; i < 16; i++) begin
      highs = 0;
      for (int c = 0; c < b; c++)
        if (start + i * b + c < tr.size() && tr[start + i * b + c][3]) highs++;
      f[15 - i] = (2 * highs > t0 + t1);
    end
    return f;
  endfunction

  // Count cycles deviating from the ideal frame + gap + first idle cycle.
  function automatic int wave_errors(input int start, input logic [15:0] f,
                                     input int b, input int t0, input int t1, input int g);
    int errs;
    int bi;
    logic pin_e;
    logic [3:0] e;
    errs = 0;
    for (int i = 0; i <= 16 * b + g; i++) begin
      pin_e = 1'b0;
      if (i < 16 * b) begin
        bi = i / b;
        pin_e = ((i % b) < (f[15 - bi] ? t1 : t0));
      end
      e = {pin_e, (i == 16 * b + g - 1), (i == 16 * b + g), (i < 16 * b + g)};
      if (start + i >= tr.size()) errs++;
      else if (tr[start + i] !== e) errs++;
    end
    return errs;
  endfunction

  task automatic wait_ready(input int sel);
    for (int i = 0; i < 5000; i++) begin
      if ((sel == 0) ? ready_a : ready_b) return;
      @(negedge clk);
    end
    n_checks++;
    n_errors++;
    $display("FAIL wait_ready: dut %0d ready=0 after 5000 cycles, want 1", sel);
  endtask

  // Called at a negedge with the selected DUT ready; tr[0] is the accept cycle.
  task automatic send_capture(input int sel, input int v, input int t, input int n);
    tr.delete();
    value     = 11'(v);
    telemetry = t[0];
    if (sel == 0) send_a = 1'b1; else send_b = 1'b1;
    @(negedge clk);
    send_a    = 1'b0;
    send_b    = 1'b0;
    value     = 11'($urandom);
    telemetry = 1'($urandom);
    grab(sel);
    for (int i = 1; i < n; i++) begin
      @(negedge clk);
      grab(sel);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; send_a = 1'b1; send_b = 1'b1; value = 11'd1046; telemetry = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({pin_a, done_a, ready_a, busy_a} !== 4'b0000) begin
      n_errors++;
      $display("FAIL reset_a: {pin,done,ready,busy}=%b want 0000", {pin_a, done_a, ready_a, busy_a});
    end
    n_checks++;
    if ({pin_b, done_b, ready_b, busy_b} !== 4'b0000) begin
      n_errors++;
      $display("FAIL reset_b: {pin,done,ready,busy}=%b want 0000", {pin_b, done_b, ready_b, busy_b});
    end
    send_a = 1'b0; send_b = 1'b0; rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({pin_a, done_a, ready_a, busy_a} !== 4'b0010) begin
      n_errors++;
      $display("FAIL post_reset_a: {pin,done,ready,busy}=%b want 0010", {pin_a, done_a, ready_a, busy_a});
    end
    n_checks++;
    if ({pin_b, done_b, ready_b, busy_b} !== 4'b0010) begin
      n_errors++;
      $display("FAIL post_reset_b: {pin,done,ready,busy}=%b want 0010", {pin_b, done_b, ready_b, busy_b});
    end
  endtask

  task automatic test_known_frames();
    int          vals[4] = '{1046, 0, 2047, 48};
    int          tels[4] = '{0, 0, 1, 0};
    logic [15:0] exp_f[4] = '{16'h82C6, 16'h0000, 16'hFFFF, 16'h0606};
    logic [15:0] got;
    int          werr;
    for (int k = 0; k < 4; k++) begin
      wait_ready(0);
      send_capture(0, vals[k], tels[k], 16 * 80 + 160 + 1);
      got = decode(0, 80, 30, 60);
      n_checks++;
      if (got !== exp_f[k]) begin
        n_errors++;
        $display("FAIL known_frame_%0d: decoded %h want %h", k, got, exp_f[k]);
      end
      werr = wave_errors(0, exp_f[k], 80, 30, 60, 160);
      n_checks++;
      if (werr !== 0) begin
        n_errors++;
        $display("FAIL known_wave_%0d: %0d bad cycles want 0", k, werr);
      end
    end
    // Loop-back view of the last (48) frame as a receiver would see it.
    n_checks++;
    if (got[3:0] !== (got[7:4] ^ got[11:8] ^ got[15:12])) begin
      n_errors++;
      $display("FAIL rx_crc_valid: crc %h payload %h", got[3:0], got[15:4]);
    end
    n_checks++;
    if (!(int'(got[15:5]) >= 48 && int'(got[15:5]) == 48)) begin
      n_errors++;
      $display("FAIL rx_speed: speed %0d want 48 (valid)", got[15:5]);
    end
  endtask

  task automatic test_random_frames();
    int          v;
    int          t;
    logic [15:0] exp_f;
    logic [15:0] got;
    int          werr;
    for (int k = 0; k < 8; k++) begin
      case (k)
        0: v = 47;
        1: v = 48;
        2: v = 1;
        3: v = 2046;
        default: v = int'($urandom_range(2047, 0));
      endcase
      t = int'($urandom_range(1, 0));
      exp_f = model_frame(v, t);
      wait_ready(0);
      send_capture(0, v, t, 16 * 80 + 160 + 1);
      got = decode(0, 80, 30, 60);
      n_checks++;
      if (got !== exp_f) begin
        n_errors++;
        $display("FAIL rand_frame v=%0d t=%0d: decoded %h want %h", v, t, got, exp_f);
      end
      werr = wave_errors(0, exp_f, 80, 30, 60, 160);
      n_checks++;
      if (werr !== 0) begin
        n_errors++;
        $display("FAIL rand_wave v=%0d t=%0d: %0d bad cycles want 0", v, t, werr);
      end
    end
  endtask

  task automatic test_back_to_back(input int sel, input int b, input int t0, input int t1,
                                   input int g, input int nframes);
    int   period = 16 * b + g + 1;
    int   total  = nframes * period + 4;
    int   starts[$];
    int   vals_q[$];
    int   tels_q[$];
    logic prev_busy;
    logic [15:0] got;
    logic [15:0] exp_f;
    int   werr;
    wait_ready(sel);
    tr.delete();
    value     = 11'($urandom);
    telemetry = 1'($urandom);
    if (sel == 0) send_a = 1'b1; else send_b = 1'b1;
    prev_busy = 1'b0;
    for (int c = 0; c < total; c++) begin
      @(negedge clk);
      grab(sel);
      if (tr[c][0] && !prev_busy) begin
        starts.push_back(c);
        vals_q.push_back(int'(value));
        tels_q.push_back(int'(telemetry));
        value     = 11'($urandom);
        telemetry = 1'($urandom);
      end else if (starts.size() > 0 && c == starts[$] + period / 2) begin
        value     = 11'($urandom);
        telemetry = 1'($urandom);
      end
      prev_busy = tr[c][0];
    end
    send_a = 1'b0;
    send_b = 1'b0;
    n_checks++;
    if (starts.size() !== nframes + 1) begin
      n_errors++;
      $display("FAIL b2b_accepts dut %0d: %0d accepts want %0d", sel, starts.size(), nframes + 1);
    end
    for (int j = 1; j < starts.size(); j++) begin
      n_checks++;
      if (starts[j] - starts[j - 1] !== period) begin
        n_errors++;
        $display("FAIL b2b_period dut %0d frame %0d: %0d cycles want %0d",
                 sel, j, starts[j] - starts[j - 1], period);
      end
    end
    for (int j = 0; j < starts.size(); j++) begin
      if (starts[j] + 16 * b + g < tr.size()) begin
        exp_f = model_frame(vals_q[j], tels_q[j]);
        got   = decode(starts[j], b, t0, t1);
        n_checks++;
        if (got !== exp_f) begin
          n_errors++;
          $display("FAIL b2b_frame dut %0d frame %0d: decoded %h want %h", sel, j, got, exp_f);
        end
        werr = wave_errors(starts[j], exp_f, b, t0, t1, g);
        n_checks++;
        if (werr !== 0) begin
          n_errors++;
          $display("FAIL b2b_wave dut %0d frame %0d: %0d bad cycles want 0", sel, j, werr);
        end
      end
    end
    wait_ready(sel);
  endtask

  task automatic test_reset_mid_frame();
    int          v;
    int          t;
    int          n_done;
    int          n_high;
    logic [15:0] exp_f;
    logic [15:0] got;
    int          werr;
    v = int'($urandom_range(2047, 48));
    t = int'($urandom_range(1, 0));
    wait_ready(0);
    send_capture(0, v, t, 7 * 80 + 6);
    n_checks++;
    if (tr[7 * 80 + 5][3] !== 1'b1) begin
      n_errors++;
      $display("FAIL mid_bit7_high: pin=%b want 1", tr[7 * 80 + 5][3]);
    end
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({pin_a, done_a, ready_a, busy_a} !== 4'b0000) begin
      n_errors++;
      $display("FAIL mid_reset_abort: {pin,done,ready,busy}=%b want 0000", {pin_a, done_a, ready_a, busy_a});
    end
    @(negedge clk);
    rst    = 1'b0;
    n_done = 0;
    n_high = 0;
    for (int c = 0; c < 16 * 80 + 200; c++) begin
      @(negedge clk);
      if (done_a) n_done++;
      if (pin_a)  n_high++;
    end
    n_checks++;
    if (n_done !== 0 || n_high !== 0) begin
      n_errors++;
      $display("FAIL mid_reset_quiet: frame_done %0d line-high %0d want 0 and 0", n_done, n_high);
    end
    v = int'($urandom_range(2047, 0));
    t = int'($urandom_range(1, 0));
    exp_f = model_frame(v, t);
    wait_ready(0);
    send_capture(0, v, t, 16 * 80 + 160 + 1);
    got = decode(0, 80, 30, 60);
    n_checks++;
    if (got !== exp_f) begin
      n_errors++;
      $display("FAIL after_reset_frame: decoded %h want %h", got, exp_f);
    end
    werr = wave_errors(0, exp_f, 80, 30, 60, 160);
    n_checks++;
    if (werr !== 0) begin
      n_errors++;
      $display("FAIL after_reset_wave: %0d bad cycles want 0", werr);
    end
  endtask

  task automatic test_small_params();
    int          v;
    int          t;
    logic [15:0] exp_f;
    logic [15:0] got;
    int          werr;
    for (int k = 0; k < 5; k++) begin
      if (k == 0) begin v = 1046; t = 0; end
      else begin v = int'($urandom_range(2047, 0)); t = int'($urandom_range(1, 0)); end
      exp_f = model_frame(v, t);
      wait_ready(1);
      send_capture(1, v, t, 16 * 8 + 1 + 1);
      got = decode(0, 8, 3, 6);
      n_checks++;
      if (got !== exp_f) begin
        n_errors++;
        $display("FAIL small_frame v=%0d t=%0d: decoded %h want %h", v, t, got, exp_f);
      end
      werr = wave_errors(0, exp_f, 8, 3, 6, 1);
      n_checks++;
      if (werr !== 0) begin
        n_errors++;
        $display("FAIL small_wave v=%0d t=%0d: %0d bad cycles want 0", v, t, werr);
      end
    end
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst       = 1'b1;
    send_a    = 1'b0;
    send_b    = 1'b0;
    value     = '0;
    telemetry = 1'b0;
    @(negedge clk);
    test_reset();
    test_known_frames();
    test_random_frames();
    test_back_to_back(0, 80, 30, 60, 160, 3);
    test_reset_mid_frame();
    test_small_params();
    test_back_to_back(1, 8, 3, 6, 1, 4);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
